w0rm_alu_multiply: RTL and testbench

//  Multiply functional unit of the W0RM core ALU. Accepts two DATA_WIDTH operands
//  and an opcode, and returns one DATA_WIDTH result slice of the 2*DATA_WIDTH product.
//  It also returns Z/N/C/V flags. It can be built as a 1-cycle registered multiplier
//  or as an iterative shift-add unit (SINGLE_CYCLE=0) for small-area builds.

---
 rtl/w0rm_alu_pkg.sv | 23 ++
 rtl/w0rm_mul_iter.sv | 57 +++++
 rtl/w0rm_alu_multiply.sv | 162 ++++++++++++++++
 tb/tb_w0rm_alu_multiply.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/w0rm_alu_pkg.sv
// Shared definitions for the W0RM ALU: opcodes, flag bit positions and
// the state encoding used by the iterative multiplier.
package w0rm_alu_pkg;

    // Multiply-unit opcodes
    localparam logic [3:0] OP_MUL   = 4'h0;
    localparam logic [3:0] OP_MULHU = 4'h1;
    localparam logic [3:0] OP_MULHS = 4'h2;

    // Bit positions inside the 4-bit flag vector
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Control states of the iterative multiplier
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/w0rm_mul_iter.sv
// Unsigned shift-add multiplier core. One partial product is accumulated per
// clock; 'done' is high during the clock whose edge completes the last step,
// so 'product' holds the full 2W result from the following cycle onward.
module w0rm_mul_iter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     op_a,
    input  logic [DATA_WIDTH-1:0]     op_b,
    output logic [2*DATA_WIDTH-1:0]   product,
    output logic                      done
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  count;
    logic           busy;

    assign done    = busy && (count == CW'(W - 1));
    assign product = acc;

    // Load operands on start, then add the shifted multiplicand for each set multiplier bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{W{1'b0}}, op_a};
            mplier <= op_b;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                busy  <= 1'b0;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/w0rm_alu_multiply.sv
// Multiply functional unit of the W0RM ALU. Returns one DATA_WIDTH slice of the
// full 2W product plus Z/N/C/V flags. SINGLE_CYCLE selects a registered
// one-cycle multiplier or a small iterative shift-add build.
module w0rm_alu_multiply
    import w0rm_alu_pkg::*;
#(
    parameter int SINGLE_CYCLE = 1,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_valid,
    input  logic [3:0]            opcode,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    output logic [3:0]            result_flags
);

    localparam int W = DATA_WIDTH;

    // Select the result slice from a full product and derive the flags.
    // Returned as {flags, result}.
    function automatic logic [W+3:0] slice_and_flags(input logic [3:0]     op,
                                                     input logic [2*W-1:0] prod);
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [W-1:0] res;
        logic         carry;
        logic [3:0]   f;
        lo    = prod[W-1:0];
        hi    = prod[2*W-1:W];
        res   = '0;
        carry = 1'b0;
        f     = '0;
        case (op)
            OP_MUL: begin
                res   = lo;
                carry = (hi != '0);
            end
            OP_MULHU: begin
                res   = hi;
                carry = (hi != '0);
            end
            OP_MULHS: begin
                res   = hi;
                carry = (hi != {W{lo[W-1]}});
            end
            default: begin
                res   = '0;
                carry = 1'b0;
            end
        endcase
        f[FLAG_Z] = (res == '0);
        f[FLAG_N] = res[W-1];
        f[FLAG_C] = carry;
        f[FLAG_V] = 1'b0;
        return {f, res};
    endfunction

    logic [W-1:0] res_q;
    logic [3:0]   flags_q;
    logic         valid_q;

    assign result       = res_q;
    assign result_flags = flags_q;
    assign result_valid = valid_q;

    if (SINGLE_CYCLE != 0) begin : g_single

        logic [2*W-1:0] prod_u;
        logic [2*W-1:0] prod_s;
        logic [2*W-1:0] prod_sel;

        assign prod_u   = {{W{1'b0}}, data_a} * {{W{1'b0}}, data_b};
        assign prod_s   = $signed({{W{data_a[W-1]}}, data_a}) * $signed({{W{data_b[W-1]}}, data_b});
        assign prod_sel = (opcode == OP_MULHS) ? prod_s : prod_u;

        // Register slice, flags and a one-cycle valid pulse on every accepted edge
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_q   <= '0;
                flags_q <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= data_valid;
                if (data_valid) begin
                    {flags_q, res_q} <= slice_and_flags(opcode, prod_sel);
                end
            end
        end

    end else begin : g_iter

        mul_state_t     state;
        logic [3:0]     op_q;
        logic           neg_q;
        logic [W-1:0]   mag_a;
        logic [W-1:0]   mag_b;
        logic           iter_start;
        logic           iter_done;
        logic [2*W-1:0] iter_prod;
        logic [2*W-1:0] prod_fixed;

        // MULHS runs on magnitudes; the most-negative value still fits as an unsigned W-bit magnitude
        assign mag_a      = (opcode == OP_MULHS && data_a[W-1]) ? -data_a : data_a;
        assign mag_b      = (opcode == OP_MULHS && data_b[W-1]) ? -data_b : data_b;
        assign iter_start = (state == ST_IDLE) && data_valid;
        assign prod_fixed = neg_q ? -iter_prod : iter_prod;

        w0rm_mul_iter #(
            .DATA_WIDTH(W)
        ) u_core (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (iter_start),
            .op_a   (mag_a),
            .op_b   (mag_b),
            .product(iter_prod),
            .done   (iter_done)
        );

        // Control FSM: capture in IDLE, wait for the core, then register the result in DONE
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= ST_IDLE;
                op_q    <= '0;
                neg_q   <= 1'b0;
                res_q   <= '0;
                flags_q <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (data_valid) begin
                            op_q  <= opcode;
                            neg_q <= (opcode == OP_MULHS) && (data_a[W-1] ^ data_b[W-1]);
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (iter_done) begin
                            state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        {flags_q, res_q} <= slice_and_flags(op_q, prod_fixed);
                        valid_q          <= 1'b1;
                        state            <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end

    end

endmodule

// File: tb/tb_w0rm_alu_multiply.sv
// Testbench for w0rm_alu_multiply: one single-cycle and one iterative instance,
// directed vectors, randomized back-to-back traffic and reset-abort checks.
module tb_w0rm_alu_multiply;

    logic       clk;
    logic       rst_n;

    logic       sc_valid;
    logic [3:0] sc_op;
    logic [7:0] sc_a;
    logic [7:0] sc_b;
    logic [7:0] sc_result;
    logic       sc_rv;
    logic [3:0] sc_flags;

    logic       it_valid;
    logic [3:0] it_op;
    logic [7:0] it_a;
    logic [7:0] it_b;
    logic [7:0] it_result;
    logic       it_rv;
    logic [3:0] it_flags;

    int passed;
    int failed;
    int total;

    w0rm_alu_multiply #(.SINGLE_CYCLE(1), .DATA_WIDTH(8)) dut_sc (
        .clk(clk), .rst_n(rst_n), .data_valid(sc_valid), .opcode(sc_op),
        .data_a(sc_a), .data_b(sc_b), .result(sc_result),
        .result_valid(sc_rv), .result_flags(sc_flags)
    );

    w0rm_alu_multiply #(.SINGLE_CYCLE(0), .DATA_WIDTH(8)) dut_it (
        .clk(clk), .rst_n(rst_n), .data_valid(it_valid), .opcode(it_op),
        .data_a(it_a), .data_b(it_b), .result(it_result),
        .result_valid(it_rv), .result_flags(it_flags)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: returns {flags, result} from integer products
    function automatic logic [11:0] refModel(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, p;
        logic [7:0] r;
        logic       c;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        r  = 8'h00;
        c  = 1'b0;
        case (op)
            4'h0: begin p = ua * ub; r = 8'(p);       c = (p > 255); end
            4'h1: begin p = ua * ub; r = 8'(p >> 8);  c = (p > 255); end
            4'h2: begin p = sa * sb; r = 8'(p >>> 8); c = (p < -128) || (p > 127); end
            default: begin r = 8'h00; c = 1'b0; end
        endcase
        return {1'b0, c, r[7], (r == 8'h00), r};
    endfunction

    // One comparison: counts, and reports on mismatch
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Run one operation on the chosen instance; exp is {flags, result}
    task automatic applyStimulus(input bit iter, input string tag, input logic [3:0] op,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input logic [11:0] exp, input bit busy_pulse);
        if (!iter) begin
            @(negedge clk);
            sc_valid = 1'b1; sc_op = op; sc_a = a; sc_b = b;
            @(negedge clk);
            sc_valid = 1'b0;
            checkOutput({tag, "_rv"},     16'(sc_rv),     16'd1);
            checkOutput({tag, "_result"}, 16'(sc_result), 16'(exp[7:0]));
            checkOutput({tag, "_flags"},  16'(sc_flags),  16'(exp[11:8]));
            @(negedge clk);
            checkOutput({tag, "_rv_pulse"}, 16'(sc_rv), 16'd0);
        end else begin
            @(negedge clk);
            it_valid = 1'b1; it_op = op; it_a = a; it_b = b;
            @(negedge clk);
            it_valid = 1'b0;
            checkOutput({tag, "_rv_t0"}, 16'(it_rv), 16'd0);
            for (int k = 1; k <= 9; k++) begin
                @(negedge clk);
                if (busy_pulse && (k == 3 || k == 8)) begin
                    it_valid = 1'b1; it_op = 4'h1; it_a = 8'hFF; it_b = 8'hFF;
                end else begin
                    it_valid = 1'b0;
                end
                if (k < 9) begin
                    checkOutput({tag, "_rv_busy"}, 16'(it_rv), 16'd0);
                end else begin
                    checkOutput({tag, "_rv"},     16'(it_rv),     16'd1);
                    checkOutput({tag, "_result"}, 16'(it_result), 16'(exp[7:0]));
                    checkOutput({tag, "_flags"},  16'(it_flags),  16'(exp[11:8]));
                end
            end
            it_valid = 1'b0;
            @(negedge clk);
            checkOutput({tag, "_rv_pulse"}, 16'(it_rv), 16'd0);
            if (busy_pulse) begin
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    checkOutput({tag, "_no_extra"}, 16'(it_rv), 16'd0);
                end
            end
        end
    endtask

    // Directed vectors with hand-derived expectations {op, a, b, flags, result}
    logic [3:0]  dir_op  [5] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h2};
    logic [7:0]  dir_a   [5] = '{8'h03, 8'h10, 8'hFF, 8'hFF, 8'h80};
    logic [7:0]  dir_b   [5] = '{8'h05, 8'h10, 8'hFF, 8'h02, 8'h80};
    logic [11:0] dir_exp [5] = '{{4'b0000, 8'h0F}, {4'b0101, 8'h00}, {4'b0110, 8'hFE},
                                 {4'b0010, 8'hFF}, {4'b0100, 8'h40}};

    logic        pend;
    logic [11:0] pend_exp;
    logic [3:0]  r_op;
    logic [7:0]  r_a;
    logic [7:0]  r_b;

    initial begin
        passed = 0; failed = 0; total = 0;
        rst_n = 1'b0;
        sc_valid = 1'b0; sc_op = '0; sc_a = '0; sc_b = '0;
        it_valid = 1'b0; it_op = '0; it_a = '0; it_b = '0;

        // Reset state of both builds
        repeat (2) @(negedge clk);
        checkOutput("rst_sc_result", 16'(sc_result), 16'd0);
        checkOutput("rst_sc_flags",  16'(sc_flags),  16'd0);
        checkOutput("rst_sc_rv",     16'(sc_rv),     16'd0);
        checkOutput("rst_it_result", 16'(it_result), 16'd0);
        checkOutput("rst_it_flags",  16'(it_flags),  16'd0);
        checkOutput("rst_it_rv",     16'(it_rv),     16'd0);
        rst_n = 1'b1;

        // Directed vectors on both builds
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, $sformatf("dir%0d_sc", i), dir_op[i], dir_a[i], dir_b[i], dir_exp[i], 1'b0);
            applyStimulus(1'b1, $sformatf("dir%0d_it", i), dir_op[i], dir_a[i], dir_b[i], dir_exp[i], 1'b0);
        end

        // Undefined opcode still completes with Z only
        applyStimulus(1'b0, "badop_sc", 4'h7, 8'h12, 8'h34, refModel(4'h7, 8'h12, 8'h34), 1'b0);
        applyStimulus(1'b1, "badop_it", 4'hC, 8'h12, 8'h34, refModel(4'hC, 8'h12, 8'h34), 1'b0);

        // Iterative build ignores data_valid while busy
        applyStimulus(1'b1, "busy_it", 4'h2, 8'h85, 8'h7B, refModel(4'h2, 8'h85, 8'h7B), 1'b1);

        // Randomized iterative operations against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            r_op = 4'($urandom_range(0, 3));
            r_a  = 8'($urandom);
            r_b  = 8'($urandom);
            applyStimulus(1'b1, $sformatf("rnd%0d_it", i), r_op, r_a, r_b, refModel(r_op, r_a, r_b), 1'b0);
        end

        // Randomized back-to-back traffic on the single-cycle build
        pend = 1'b0;
        pend_exp = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checkOutput("b2b_sc_rv", 16'(sc_rv), 16'(pend));
            if (pend) begin
                checkOutput("b2b_sc_result", 16'(sc_result), 16'(pend_exp[7:0]));
                checkOutput("b2b_sc_flags",  16'(sc_flags),  16'(pend_exp[11:8]));
            end
            sc_valid = ($urandom_range(0, 3) != 0);
            sc_op    = 4'($urandom_range(0, 3));
            sc_a     = 8'($urandom);
            sc_b     = 8'($urandom);
            pend     = sc_valid;
            pend_exp = refModel(sc_op, sc_a, sc_b);
        end
        @(negedge clk);
        sc_valid = 1'b0;
        checkOutput("b2b_sc_rv_last", 16'(sc_rv), 16'(pend));
        if (pend) begin
            checkOutput("b2b_sc_result_last", 16'(sc_result), 16'(pend_exp[7:0]));
        end

        // Reset in the middle of an iterative run aborts it
        @(negedge clk);
        it_valid = 1'b1; it_op = 4'h0; it_a = 8'h03; it_b = 8'h05;
        @(negedge clk);
        it_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_it_result", 16'(it_result), 16'd0);
        checkOutput("midrst_it_flags",  16'(it_flags),  16'd0);
        checkOutput("midrst_it_rv",     16'(it_rv),     16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checkOutput("midrst_it_no_result", 16'(it_rv), 16'd0);
        end

        // Unit is usable again after the abort
        applyStimulus(1'b1, "postrst_it", 4'h1, 8'hFF, 8'hFF, 16'h6FE, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
